// File: rtl/host_loader.sv
// -----------------------------------------------------------------------------
// host_loader
//
// Upstream feeder for the matrix coprocessor. Accepts a host word stream over a
// valid/ready handshake. The first word of a job is a header whose bits [15:0]
// give the data word count N. The header is written verbatim to line 0. The N
// data words that follow are packed BLOCK_SIZE per line and written to lines
// 1, 2, ... Lane 0 holds the first word of a line. After the last line, the
// loader writes the start bit into the status word, then waits for the done bit
// (in_status[1]) before it accepts the next job.
//
// Ports:
//   in_clk, in_reset        clock, synchronous active-high reset
//   in_host_data/valid      host word stream
//   out_host_ready          loader accepts a word this cycle
//   out_mem_address/data    memory line address / line write data
//   out_mem_write_en        line write strobe (one cycle per line)
//   out_status              status word to write (start bit = bit 0)
//   out_write_status_en     status write strobe
//   in_status               status read back from memory (done = bit 1)
//   out_busy                job in progress
//   out_done                one-cycle pulse when the job completes
//   out_overflow            sticky: data exceeded memory capacity
//   out_checksum            sum of the job's data words, modulo 2^WORD_SIZE
//                           (present only when HOST_LOADER_CHECKSUM_EN is defined)
//
// Optional feature macro: HOST_LOADER_CHECKSUM_EN
// -----------------------------------------------------------------------------
module host_loader #(
   parameter int WORD_SIZE       = 32,
   parameter int BLOCK_SIZE      = 3,
   parameter int MEMORY_SIZE     = 1024,
   parameter int LOG_MEMORY_SIZE = $clog2(MEMORY_SIZE)
) (
   input  logic                            in_clk,
   input  logic                            in_reset,
   input  logic [WORD_SIZE-1:0]            in_host_data,
   input  logic                            in_host_valid,
   output logic                            out_host_ready,
   output logic [LOG_MEMORY_SIZE-1:0]      out_mem_address,
   output logic [BLOCK_SIZE*WORD_SIZE-1:0] out_mem_data,
   output logic                            out_mem_write_en,
   output logic [WORD_SIZE-1:0]            out_status,
   output logic                            out_write_status_en,
   input  logic [WORD_SIZE-1:0]            in_status,
   output logic                            out_busy,
   output logic                            out_done,
   output logic                            out_overflow
`ifdef HOST_LOADER_CHECKSUM_EN
   ,
   output logic [WORD_SIZE-1:0]            out_checksum
`endif
);

   localparam int LANE_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      FLUSH,
      STATUS,
      WAIT_DONE
   } state_t;

   state_t                                  state;
   logic                                    host_ready;
   logic                                    accept;

   // lane buffer for the line being assembled
   logic [BLOCK_SIZE-1:0][WORD_SIZE-1:0]    lanes;
   logic [BLOCK_SIZE-1:0][WORD_SIZE-1:0]    line_next;
   logic [LANE_W-1:0]                       lane_idx;
   logic                                    lane_last;

   // job bookkeeping
   logic [15:0]                             n_words;
   logic [15:0]                             word_cnt;
   logic                                    word_last;
   logic [LOG_MEMORY_SIZE-1:0]              line_addr;
   logic                                    mem_full;

   // registered line write port
   logic [BLOCK_SIZE-1:0][WORD_SIZE-1:0]    line_p1;
   logic [LOG_MEMORY_SIZE-1:0]              addr_p1;
   logic                                    vld_p1;

   logic [WORD_SIZE-1:0]                    status_word;
   logic                                    status_en;
   logic                                    busy;
   logic                                    done;
   logic                                    overflow;

`ifdef HOST_LOADER_CHECKSUM_EN
   logic [WORD_SIZE-1:0]                    checksum;
   assign out_checksum = checksum;
`endif

   // only the done bit of the status word is consumed
   logic unused_status;
   assign unused_status = ^{in_status[WORD_SIZE-1:2], in_status[0]};

   assign accept    = in_host_valid & host_ready;
   assign lane_last = (lane_idx == LANE_W'(BLOCK_SIZE - 1));
   assign word_last = ((word_cnt + 16'd1) == n_words);

   always_comb begin
      line_next           = lanes;
      line_next[lane_idx] = in_host_data;
   end

   // ---- stage p0 -> p1: handshake, packing and control ----
   always_ff @(posedge in_clk) begin
      if (in_reset) begin
         state       <= IDLE;
         host_ready  <= 1'b1;
         lanes       <= '0;
         lane_idx    <= '0;
         n_words     <= '0;
         word_cnt    <= '0;
         line_addr   <= LOG_MEMORY_SIZE'(1);
         mem_full    <= 1'b0;
         line_p1     <= '0;
         addr_p1     <= '0;
         vld_p1      <= 1'b0;
         status_word <= '0;
         status_en   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         overflow    <= 1'b0;
`ifdef HOST_LOADER_CHECKSUM_EN
         checksum    <= '0;
`endif
      end else begin
         // strobes are single-cycle unless re-asserted below
         vld_p1      <= 1'b0;
         status_en   <= 1'b0;
         status_word <= '0;
         done        <= 1'b0;

         case (state)
            IDLE: begin
               if (accept) begin
                  // header goes out verbatim as the config line at address 0
                  line_p1    <= '0;
                  line_p1[0] <= in_host_data;
                  addr_p1    <= '0;
                  vld_p1     <= 1'b1;
                  busy       <= 1'b1;
                  overflow   <= 1'b0;
                  n_words    <= in_host_data[15:0];
                  word_cnt   <= '0;
                  lanes      <= '0;
                  lane_idx   <= '0;
                  line_addr  <= LOG_MEMORY_SIZE'(1);
                  mem_full   <= 1'b0;
`ifdef HOST_LOADER_CHECKSUM_EN
                  checksum   <= '0;
`endif
                  if (in_host_data[15:0] == 16'd0) begin
                     host_ready <= 1'b0;
                     state      <= STATUS;
                  end else begin
                     state      <= LOAD;
                  end
               end
            end

            LOAD: begin
               if (accept) begin
                  word_cnt <= word_cnt + 16'd1;
`ifdef HOST_LOADER_CHECKSUM_EN
                  checksum <= checksum + in_host_data;
`endif
                  if (!mem_full) begin
                     if (lane_last) begin
                        line_p1  <= line_next;
                        addr_p1  <= line_addr;
                        vld_p1   <= 1'b1;
                        lanes    <= '0;
                        lane_idx <= '0;
                        // the top line is the last one; the address never wraps
                        if (line_addr == LOG_MEMORY_SIZE'(MEMORY_SIZE - 1))
                           mem_full  <= 1'b1;
                        else
                           line_addr <= line_addr + LOG_MEMORY_SIZE'(1);
                     end else begin
                        lanes    <= line_next;
                        lane_idx <= lane_idx + LANE_W'(1);
                     end
                  end else begin
                     overflow <= 1'b1;
                  end

                  if (word_last) begin
                     host_ready <= 1'b0;
                     // a stored word that did not close its line leaves a partial line
                     if (!mem_full && !lane_last)
                        state <= FLUSH;
                     else
                        state <= STATUS;
                  end
               end
            end

            FLUSH: begin
               // unfilled lanes are already zero because the buffer is cleared per line
               line_p1  <= lanes;
               addr_p1  <= line_addr;
               vld_p1   <= 1'b1;
               lanes    <= '0;
               lane_idx <= '0;
               state    <= STATUS;
            end

            STATUS: begin
               // any pending line write drains this cycle, so the status write follows it
               status_word <= WORD_SIZE'(1);
               status_en   <= 1'b1;
               state       <= WAIT_DONE;
            end

            WAIT_DONE: begin
               if (in_status[1]) begin
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  host_ready <= 1'b1;
                  state      <= IDLE;
               end
            end

            default: begin
               state      <= IDLE;
               host_ready <= 1'b1;
            end
         endcase
      end
   end

   // ---- stage p1: registered outputs ----
   assign out_host_ready      = host_ready;
   assign out_mem_address     = addr_p1;
   assign out_mem_data        = line_p1;
   assign out_mem_write_en    = vld_p1;
   assign out_status          = status_word;
   assign out_write_status_en = status_en;
   assign out_busy            = busy;
   assign out_done            = done;
   assign out_overflow        = overflow;

endmodule

// File: tb/tb_host_loader.sv
module tb_host_loader;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_tests = 0;
   int n_fail  = 0;

   // DUT a: default configuration
   logic [31:0] a_data = '0, a_sin = '0;
   logic        a_valid = 1'b0;
   logic        a_ready, a_we, a_st_en, a_busy, a_done, a_ovf;
   logic [9:0]  a_addr;
   logic [95:0] a_mdata;
   logic [31:0] a_status;

   // DUT b: four-line memory for overflow
   logic [31:0] b_data = '0, b_sin = '0;
   logic        b_valid = 1'b0;
   logic        b_ready, b_we, b_st_en, b_busy, b_done, b_ovf;
   logic [1:0]  b_addr;
   logic [95:0] b_mdata;
   logic [31:0] b_status;

`ifdef HOST_LOADER_CHECKSUM_EN
   logic [31:0] a_csum, b_csum;
`endif

   host_loader #(.WORD_SIZE(32), .BLOCK_SIZE(3), .MEMORY_SIZE(1024)) dut_a (
      .in_clk(clk), .in_reset(rst),
      .in_host_data(a_data), .in_host_valid(a_valid), .out_host_ready(a_ready),
      .out_mem_address(a_addr), .out_mem_data(a_mdata), .out_mem_write_en(a_we),
      .out_status(a_status), .out_write_status_en(a_st_en), .in_status(a_sin),
      .out_busy(a_busy), .out_done(a_done), .out_overflow(a_ovf)
`ifdef HOST_LOADER_CHECKSUM_EN
      , .out_checksum(a_csum)
`endif
   );

   host_loader #(.WORD_SIZE(32), .BLOCK_SIZE(3), .MEMORY_SIZE(4)) dut_b (
      .in_clk(clk), .in_reset(rst),
      .in_host_data(b_data), .in_host_valid(b_valid), .out_host_ready(b_ready),
      .out_mem_address(b_addr), .out_mem_data(b_mdata), .out_mem_write_en(b_we),
      .out_status(b_status), .out_write_status_en(b_st_en), .in_status(b_sin),
      .out_busy(b_busy), .out_done(b_done), .out_overflow(b_ovf)
`ifdef HOST_LOADER_CHECKSUM_EN
      , .out_checksum(b_csum)
`endif
   );

   // write logs, sampled on the falling edge
   logic [9:0]  a_wa[$];
   logic [95:0] a_wd[$];
   int          a_wc[$];
   int          a_st_n = 0, a_st_cyc = 0, a_done_n = 0, a_clash = 0;
   logic [31:0] a_st_val = '0;
   logic [1:0]  b_wa[$];
   logic [95:0] b_wd[$];
   int          b_st_n = 0, b_clash = 0;
   logic [31:0] b_st_val = '0;

   always @(negedge clk) begin
      if (!rst) begin
         if (a_we) begin a_wa.push_back(a_addr); a_wd.push_back(a_mdata); a_wc.push_back(cyc); end
         if (a_st_en) begin a_st_n++; a_st_cyc = cyc; a_st_val = a_status; end
         if (a_we && a_st_en) a_clash++;
         if (a_done) a_done_n++;
         if (b_we) begin b_wa.push_back(b_addr); b_wd.push_back(b_mdata); end
         if (b_st_en) begin b_st_n++; b_st_val = b_status; end
         if (b_we && b_st_en) b_clash++;
      end
   end

   task automatic clear_logs();
      a_wa.delete(); a_wd.delete(); a_wc.delete();
      a_st_n = 0; a_done_n = 0; a_clash = 0; a_st_val = '0;
      b_wa.delete(); b_wd.delete();
      b_st_n = 0; b_clash = 0; b_st_val = '0;
   endtask

   // offers one word; returns the number of clock edges until it was taken
   task automatic send(input bit ov, input logic [31:0] d, output int waited);
      bit r;
      r = 1'b0;
      waited = 0;
      if (ov) begin b_data = d; b_valid = 1'b1; end
      else    begin a_data = d; a_valid = 1'b1; end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         r = ov ? b_ready : a_ready;
         @(posedge clk); #1;
         waited++;
         if (r) break;
      end
      if (ov) b_valid = 1'b0; else a_valid = 1'b0;
      if (!r) begin
         n_tests++; n_fail++;
         $display("FAIL send_timeout word=%h got no ready, required ready within 40 cycles", d);
      end
   endtask

   task automatic wait_status(input bit ov, input string tag);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk); #1;
         got = ov ? (b_st_n > 0) : (a_st_n > 0);
      end
      n_tests++;
      if (!got) begin n_fail++; $display("FAIL %s_status_timeout got no status write, required one", tag); end
   endtask

   task automatic finish_job(input bit ov, input string tag);
      bit got;
      got = 1'b0;
      if (ov) b_sin = 32'h2; else a_sin = 32'h2;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = ov ? b_done : a_done;
      end
      if (ov) b_sin = '0; else a_sin = '0;
      @(posedge clk); #1;
      n_tests++;
      if (!got) begin n_fail++; $display("FAIL %s_done_timeout got no done pulse, required one", tag); end
   endtask

   task automatic test_reset();
      rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", a_ready); end
      n_tests++; if (a_we !== 1'b0)    begin n_fail++; $display("FAIL rst_we got %b exp 0", a_we); end
      n_tests++; if (a_st_en !== 1'b0) begin n_fail++; $display("FAIL rst_st_en got %b exp 0", a_st_en); end
      n_tests++; if (a_status !== 32'h0) begin n_fail++; $display("FAIL rst_status got %h exp 0", a_status); end
      n_tests++; if (a_busy !== 1'b0)  begin n_fail++; $display("FAIL rst_busy got %b exp 0", a_busy); end
      n_tests++; if (a_done !== 1'b0)  begin n_fail++; $display("FAIL rst_done got %b exp 0", a_done); end
      n_tests++; if (a_ovf !== 1'b0)   begin n_fail++; $display("FAIL rst_ovf got %b exp 0", a_ovf); end
      n_tests++; if (a_addr !== 10'h0) begin n_fail++; $display("FAIL rst_addr got %h exp 0", a_addr); end
      n_tests++; if (a_mdata !== 96'h0) begin n_fail++; $display("FAIL rst_mdata got %h exp 0", a_mdata); end
      n_tests++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL rst_b_ready got %b exp 1", b_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [9:0]  ea [3];
      logic [95:0] ed [3];
      int w, total;
      ea = '{10'd0, 10'd1, 10'd2};
      ed = '{96'h00000000_00000000_00050005,
             96'h00000003_00000002_00000001,
             96'h00000000_00000005_00000004};
      clear_logs();
      send(0, 32'h00050005, w); total = w;
      for (int k = 1; k <= 5; k++) begin send(0, k, w); total += w; end
      wait_status(0, "basic");
      n_tests++; if (total !== 6) begin n_fail++; $display("FAIL basic_b2b_cycles got %0d exp 6", total); end
      n_tests++; if (a_wa.size() !== 3) begin n_fail++; $display("FAIL basic_wr_count got %0d exp 3", a_wa.size()); end
      for (int i = 0; i < 3 && i < a_wa.size(); i++) begin
         n_tests++; if (a_wa[i] !== ea[i]) begin n_fail++; $display("FAIL basic_addr%0d got %0d exp %0d", i, a_wa[i], ea[i]); end
         n_tests++; if (a_wd[i] !== ed[i]) begin n_fail++; $display("FAIL basic_data%0d got %h exp %h", i, a_wd[i], ed[i]); end
      end
      n_tests++; if (a_st_n !== 1) begin n_fail++; $display("FAIL basic_st_count got %0d exp 1", a_st_n); end
      n_tests++; if (a_st_val !== 32'h1) begin n_fail++; $display("FAIL basic_st_val got %h exp 1", a_st_val); end
      if (a_wc.size() == 3) begin
         n_tests++; if (a_st_cyc !== a_wc[2] + 1) begin n_fail++; $display("FAIL basic_st_order got cyc %0d exp %0d", a_st_cyc, a_wc[2] + 1); end
      end
      n_tests++; if (a_clash !== 0) begin n_fail++; $display("FAIL basic_clash got %0d exp 0", a_clash); end
      n_tests++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b exp 1", a_busy); end
      n_tests++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL basic_wait_ready got %b exp 0", a_ready); end
      n_tests++; if (a_status !== 32'h0) begin n_fail++; $display("FAIL basic_status_after got %h exp 0", a_status); end
   endtask

   task automatic test_completion();
      a_sin = 32'h2;
      @(negedge clk);
      n_tests++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL cmp_done_early got %b exp 0", a_done); end
      @(negedge clk);
      n_tests++; if (a_done !== 1'b1)  begin n_fail++; $display("FAIL cmp_done got %b exp 1", a_done); end
      n_tests++; if (a_busy !== 1'b0)  begin n_fail++; $display("FAIL cmp_busy got %b exp 0", a_busy); end
      n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL cmp_ready got %b exp 1", a_ready); end
      a_sin = '0;
      @(negedge clk);
      n_tests++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL cmp_done_width got %b exp 0", a_done); end
      n_tests++; if (a_done_n !== 1)  begin n_fail++; $display("FAIL cmp_done_count got %0d exp 1", a_done_n); end
`ifdef HOST_LOADER_CHECKSUM_EN
      n_tests++; if (a_csum !== 32'd15) begin n_fail++; $display("FAIL cmp_checksum got %0d exp 15", a_csum); end
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_empty();
      int w;
      clear_logs();
      send(0, 32'h00000000, w);
      wait_status(0, "empty");
      n_tests++; if (a_wa.size() !== 1) begin n_fail++; $display("FAIL empty_wr_count got %0d exp 1", a_wa.size()); end
      if (a_wa.size() >= 1) begin
         n_tests++; if (a_wa[0] !== 10'd0) begin n_fail++; $display("FAIL empty_addr got %0d exp 0", a_wa[0]); end
         n_tests++; if (a_wd[0] !== 96'h0) begin n_fail++; $display("FAIL empty_data got %h exp 0", a_wd[0]); end
         n_tests++; if (a_st_cyc !== a_wc[0] + 1) begin n_fail++; $display("FAIL empty_st_order got cyc %0d exp %0d", a_st_cyc, a_wc[0] + 1); end
      end
      n_tests++; if (a_st_val !== 32'h1) begin n_fail++; $display("FAIL empty_st_val got %h exp 1", a_st_val); end
      finish_job(0, "empty");
   endtask

   task automatic test_backpressure();
      logic [95:0] ed [3];
      int w;
      ed = '{96'h00000000_00000000_00050005,
             96'h00000003_00000002_00000001,
             96'h00000000_00000005_00000004};
      clear_logs();
      send(0, 32'h00050005, w);
      for (int k = 1; k <= 5; k++) begin
         repeat (2) @(posedge clk);
         #1;
         send(0, k, w);
      end
      wait_status(0, "bp");
      n_tests++; if (a_wa.size() !== 3) begin n_fail++; $display("FAIL bp_wr_count got %0d exp 3", a_wa.size()); end
      for (int i = 0; i < 3 && i < a_wa.size(); i++) begin
         n_tests++; if (a_wa[i] !== 10'(i)) begin n_fail++; $display("FAIL bp_addr%0d got %0d exp %0d", i, a_wa[i], i); end
         n_tests++; if (a_wd[i] !== ed[i]) begin n_fail++; $display("FAIL bp_data%0d got %h exp %h", i, a_wd[i], ed[i]); end
      end
      n_tests++; if (a_st_n !== 1) begin n_fail++; $display("FAIL bp_st_count got %0d exp 1", a_st_n); end
      finish_job(0, "bp");
`ifdef HOST_LOADER_CHECKSUM_EN
      n_tests++; if (a_csum !== 32'd15) begin n_fail++; $display("FAIL bp_checksum got %0d exp 15", a_csum); end
`endif
   endtask

   task automatic test_reset_mid_load();
      int w;
      clear_logs();
      send(0, 32'h00050005, w);
      send(0, 32'd1, w);
      send(0, 32'd2, w);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got %b exp 1", a_ready); end
      n_tests++; if (a_busy !== 1'b0)  begin n_fail++; $display("FAIL mid_busy got %b exp 0", a_busy); end
      n_tests++; if (a_we !== 1'b0)    begin n_fail++; $display("FAIL mid_we got %b exp 0", a_we); end
      n_tests++; if (a_mdata !== 96'h0) begin n_fail++; $display("FAIL mid_mdata got %h exp 0", a_mdata); end
      n_tests++; if (a_addr !== 10'h0) begin n_fail++; $display("FAIL mid_addr got %h exp 0", a_addr); end
      @(posedge clk); #1;
      clear_logs();
      send(0, 32'h00000003, w);
      send(0, 32'd7, w);
      send(0, 32'd8, w);
      send(0, 32'd9, w);
      wait_status(0, "mid");
      n_tests++; if (a_wa.size() !== 2) begin n_fail++; $display("FAIL mid_wr_count got %0d exp 2", a_wa.size()); end
      if (a_wa.size() >= 2) begin
         n_tests++; if (a_wa[0] !== 10'd0) begin n_fail++; $display("FAIL mid_addr0 got %0d exp 0", a_wa[0]); end
         n_tests++; if (a_wd[0] !== 96'h00000000_00000000_00000003) begin n_fail++; $display("FAIL mid_data0 got %h exp 3", a_wd[0]); end
         n_tests++; if (a_wa[1] !== 10'd1) begin n_fail++; $display("FAIL mid_addr1 got %0d exp 1", a_wa[1]); end
         n_tests++; if (a_wd[1] !== 96'h00000009_00000008_00000007) begin n_fail++; $display("FAIL mid_data1 got %h exp 000000090000000800000007", a_wd[1]); end
      end
      finish_job(0, "mid");
`ifdef HOST_LOADER_CHECKSUM_EN
      n_tests++; if (a_csum !== 32'd24) begin n_fail++; $display("FAIL mid_checksum got %0d exp 24", a_csum); end
`endif
   endtask

   task automatic test_overflow();
      logic [1:0]  ea [4];
      logic [95:0] ed [4];
      int w;
      ea = '{2'd0, 2'd1, 2'd2, 2'd3};
      ed = '{96'h00000000_00000000_0000000C,
             96'h00000003_00000002_00000001,
             96'h00000006_00000005_00000004,
             96'h00000009_00000008_00000007};
      clear_logs();
      send(1, 32'h0000000C, w);
      for (int k = 1; k <= 12; k++) begin
         send(1, k, w);
         if (k == 9) begin
            n_tests++; if (b_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_before got %b exp 0", b_ovf); end
         end
         if (k == 10) begin
            n_tests++; if (b_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_at10 got %b exp 1", b_ovf); end
         end
      end
      wait_status(1, "ovf");
      n_tests++; if (b_wa.size() !== 4) begin n_fail++; $display("FAIL ovf_wr_count got %0d exp 4", b_wa.size()); end
      for (int i = 0; i < 4 && i < b_wa.size(); i++) begin
         n_tests++; if (b_wa[i] !== ea[i]) begin n_fail++; $display("FAIL ovf_addr%0d got %0d exp %0d", i, b_wa[i], ea[i]); end
         n_tests++; if (b_wd[i] !== ed[i]) begin n_fail++; $display("FAIL ovf_data%0d got %h exp %h", i, b_wd[i], ed[i]); end
      end
      n_tests++; if (b_st_val !== 32'h1) begin n_fail++; $display("FAIL ovf_st_val got %h exp 1", b_st_val); end
      n_tests++; if (b_clash !== 0) begin n_fail++; $display("FAIL ovf_clash got %0d exp 0", b_clash); end
      finish_job(1, "ovf");
      n_tests++; if (b_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", b_ovf); end
`ifdef HOST_LOADER_CHECKSUM_EN
      n_tests++; if (b_csum !== 32'd78) begin n_fail++; $display("FAIL ovf_checksum got %0d exp 78", b_csum); end
`endif
      clear_logs();
      send(1, 32'h00000000, w);
      n_tests++; if (b_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", b_ovf); end
      wait_status(1, "ovf2");
      finish_job(1, "ovf2");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_completion();
      test_empty();
      test_backpressure();
      test_reset_mid_load();
      test_overflow();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/host_loader.md
Name: host_loader

Overview:
- Upstream feeder for the matrix coprocessor. Takes a host word stream using a valid/ready handshake.
- Packs the words into BLOCK_SIZE-wide memory lines and writes them into the shared memory before any processor runs.
- After the last line, writes the start bit into the status word, then waits for the main controller's done bit before accepting the next job.

Parameters:
- WORD_SIZE, 32, width of one matrix cell / host word
- BLOCK_SIZE, 3, words per memory line
- MEMORY_SIZE, 1024, memory depth in lines
- LOG_MEMORY_SIZE, $clog2(MEMORY_SIZE), memory address width

Ports:
- in_clk  input  1  clock
- in_reset  input  1  synchronous active-high reset
- in_host_data  input  WORD_SIZE  host word
- in_host_valid  input  1  host word valid
- out_host_ready  output  1  loader accepts word this cycle
- out_mem_address  output  LOG_MEMORY_SIZE  memory line address
- out_mem_data  output  BLOCK_SIZE*WORD_SIZE  memory line write data
- out_mem_write_en  output  1  memory line write strobe
- out_status  output  WORD_SIZE  status word to write
- out_write_status_en  output  1  status write strobe
- in_status  input  WORD_SIZE  status read back from memory
- out_busy  output  1  job in progress
- out_done  output  1  one-cycle pulse when job completes
- out_overflow  output  1  sticky; data exceeded memory capacity

Behaviour:
- Clock and reset: one clock in_clk; reset in_reset is synchronous and active-high.
- Reset values:
  - all outputs 0, except out_host_ready=1
  - state IDLE; counters and lane buffer cleared
  - reset mid-job abandons the job; no further writes; next accepted word is treated as a header.
- Handshake: a word transfers when in_host_valid & out_host_ready. The host may hold valid low for any number of cycles.
- Lane packing: lane k occupies bits [k*WORD_SIZE +: WORD_SIZE]. Lane 0 is the first word of the line.
- IDLE:
  - ready=1
  - first accepted word is the header; bits [15:0] give data word count N
  - the header is written verbatim as the config line: address 0, lane 0 = header, other lanes 0
  - out_mem_write_en pulses the cycle after acceptance; out_busy=1 from that cycle
  - go to LOAD (N>0) or STATUS (N=0).
- LOAD:
  - ready=1; accepted words fill lanes 0..BLOCK_SIZE-1
  - on accepting the word in lane BLOCK_SIZE-1, the line is copied to an output register and a write is issued the next cycle
  - line addresses start at 1 and increment by 1 per line
  - accepting continues without a gap; one word per cycle sustained
  - after the N-th word: if the line is partial, go to FLUSH; otherwise go to STATUS after the final write.
- FLUSH:
  - ready=0
  - write the partial line with unfilled lanes forced to 0 (one write cycle), then go to STATUS.
- Capacity and overflow:
  - capacity is (MEMORY_SIZE-1)*BLOCK_SIZE words
  - words beyond capacity are still accepted (counted toward N) but never written
  - out_overflow goes to 1 on the first dropped word and stays set until the next header is accepted
  - the address never wraps to 0.
- STATUS:
  - ready=0
  - one-cycle pulse of out_write_status_en with out_status=1 (bit0 = start); out_status returns to 0 afterwards
  - go to WAIT_DONE.
- WAIT_DONE:
  - ready=0
  - when in_status[1]=1: out_done pulses one cycle, out_busy=0, ready=1, back to IDLE
  - in_status already showing done on the first WAIT_DONE cycle counts as done.
- Ordering: the header write always precedes data writes. At most one memory write per cycle. A status write never coincides with a line write.

Optional Feature:
- Macro: HOST_LOADER_CHECKSUM_EN.
- With the macro defined:
  - extra output out_checksum (WORD_SIZE) holding the modulo-2^WORD_SIZE sum of all accepted data words of the current job, header excluded
  - cleared on header accept; dropped overflow words included
  - value stable from the cycle out_busy falls until the next header.
- Without the macro: port and adder absent; behaviour otherwise identical.

Test Plan:
- Basic job (BLOCK_SIZE=3, WORD_SIZE=32, MEMORY_SIZE=1024): header 0x00050005, then words 1,2,3,4,5 back-to-back -> expected writes:
  - addr0 = {0,0,0x00050005}
  - addr1 = {3,2,1}
  - addr2 = {0,5,4}
  - then one status write with out_status=0x1; out_busy=1.
- Completion: after the basic job, drive in_status=0x2 -> out_done pulses exactly 1 cycle; out_busy=0; out_host_ready=1 the same cycle.
- Empty job: header 0x00000000 -> addr0 write, then the status write immediately; no data-line writes.
- Backpressure: basic job with valid low for 2 cycles between each word -> identical write contents and addresses, one write per full line.
- Reset mid-LOAD: reset after word 2 of the basic job -> all outputs 0 next cycle, ready=1; a new header 0x00000003 with words 7,8,9 -> addr1={9,8,7}.
- Overflow (MEMORY_SIZE=4): header N=12, words 1..12 -> lines 1..3 written with words 1..9; words 10..12 dropped; out_overflow=1 from the word-10 accept; the status write still occurs.
